movavg_lane_serializer: RTL
===========================

// Module: movavg_lane_serializer
// PURPOSE
//  Sits directly downstream of movavg. Consumes the two 4-tap sums movavg
//  produces every cycle (doutB = older lane, doutA = newer lane).
//  Normalises each sum to an average with an optional rounding right-shift.
//  Emits the averages as one time-ordered stream with a valid/ready
//  handshake, buffered in a small FIFO.
// PARAMETERS
//  WIDTH  64  data width of input sums and output averages
//  DEPTH  8   FIFO depth in single-lane words; power of two, >= 4
//  SHIFT  2   right-shift applied to each sum (2 = divide by 4 taps)
//  ROUND  1   1 = round half up before the shift; 0 = truncate
// PORTS
//  clk        in   1          clock; all logic on rising edge
//  reset      in   1          synchronous, active-low reset
//  in_valid   in   1          sum pair present on sumA/sumB
//  in_ready   out  1          block can accept a pair this cycle
//  sumA       in   WIDTH      newer-lane sum (movavg doutA)
//  sumB       in   WIDTH      older-lane sum (movavg doutB)
//  out_valid  out  1          out_data holds a valid average
//  out_ready  in   1          sink accepts out_data this cycle
//  out_data   out  WIDTH      normalised average, oldest first
//  out_lane   out  1          source lane of out_data: 0 = B, 1 = A
//  level      out  log2(DEPTH)+1  current FIFO occupancy in words
// BEHAVIOUR
//  - Reset (reset==0 at rising clk):
//    - rd/wr pointers and level go to 0; out_valid=0.
//    - out_data=0, out_lane=0; in_ready=1 in the following cycle.
//    - Reset mid-operation discards all buffered words; no partial pair survives.
//  - Normalise:
//    - n = ROUND&&SHIFT>0 ? (sum + (1<<(SHIFT-1))) >> SHIFT : sum >> SHIFT.
//    - The add is done in WIDTH+1 bits so the carry is kept.
//    - The result always fits in WIDTH bits; no saturation is needed.
//  - Handshake:
//    - in_ready = (level <= DEPTH-2); combinational from registered level only.
//    - Push happens when in_valid && in_ready. It writes n(sumB),lane0 at wr_ptr
//      and n(sumA),lane1 at wr_ptr+1 (mod DEPTH), then wr_ptr += 2.
//    - sumA/sumB are ignored when in_valid=0 or in_ready=0; no pair is ever split.
//  - Output:
//    - out_valid = (level != 0); out_data/out_lane show the head entry.
//    - When out_valid=0, out_data=0 and out_lane=0.
//    - Pop happens when out_valid && out_ready; rd_ptr += 1. At most one word per cycle.
//    - out_data/out_lane stay stable while out_valid && !out_ready.
//  - Level update per cycle:
//    - push only: +2; pop only: -1; push and pop together: +1; neither: unchanged.
//    - A word pushed in cycle t is visible on out_data no earlier than cycle t+1
//      (no write-through).
//  - Pointers wrap modulo DEPTH.
//  - level never exceeds DEPTH and never underflows; either is an assertion error.
//  - Throughput: input may be 2 words/cycle, output is 1 word/cycle.
//    Sustained in_valid=1 therefore stalls in_ready about every other cycle
//    once the FIFO fills. The upstream stage must hold its pair while stalled.
// TESTING
//  1 Rounding, SHIFT=2, ROUND=1: one pair sumB=0x10, sumA=0x13, out_ready=1
//    -> out 0x4 (lane0), then 0x5 (lane1); level returns to 0.
//  2 Carry: sumA=sumB=64'hFFFF_FFFF_FFFF_FFFF
//    -> both outputs 64'h4000_0000_0000_0000; with ROUND=0 -> 64'h3FFF_FFFF_FFFF_FFFF.
//  3 Fill, DEPTH=8, out_ready=0: push 4 pairs
//    -> level 2,4,6,8; in_ready=0 when level=8 and also at level 7.
//    A 5th pair is not accepted.
//  4 Simultaneous push/pop: at level=4, in_valid=1 and out_ready=1
//    -> level=5 next cycle, head advances by exactly one word.
//  5 Backpressure: out_ready toggles 1,0,1,0 while 16 random pairs are pushed
//    -> 32 words out, order B0,A0,B1,A1,...
//    Each word equals the model value; no loss or duplication across pointer wrap.
//  6 Reset mid-stream: reset=0 for 1 cycle at level=5
//    -> next cycle level=0, out_valid=0, out_data=0, in_ready=1.
//    The next pair pushed is the first word out.

Source files
------------

// File: rtl/movavg_lane_serializer.sv
// Normalises the two per-cycle movavg lane sums and serialises them, older lane first,
// through a small FIFO with valid/ready on both sides.
module movavg_lane_serializer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SHIFT = 2,
  parameter int unsigned ROUND = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         sumA,
  input  logic [WIDTH-1:0]         sumB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_lane,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [WIDTH:0] RndAdd = (ROUND != 0 && SHIFT > 0) ?
      ((WIDTH + 1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;

  // Extra bit keeps the rounding carry of an all-ones sum.
  function automatic logic [WIDTH-1:0] normalise(input logic [WIDTH-1:0] sum);
    logic [WIDTH:0] ext;
    ext = ({1'b0, sum} + RndAdd) >> SHIFT;
    return WIDTH'(ext);
  endfunction

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] lane_q, lane_d;
  logic             push, pop;

  assign in_ready  = (level_q <= LW'(DEPTH - 2));
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? data_q[rd_ptr_q] : '0;
  assign out_lane  = out_valid ? lane_q[rd_ptr_q] : 1'b0;
  assign level     = level_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    data_d   = data_q;
    lane_d   = lane_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      data_d[wr_ptr_q]          = normalise(sumB);
      lane_d[wr_ptr_q]          = 1'b0;
      data_d[wr_ptr_q + PW'(1)] = normalise(sumA);
      lane_d[wr_ptr_q + PW'(1)] = 1'b1;
      wr_ptr_d                  = wr_ptr_q + PW'(2);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(2);
      2'b01:   level_d = level_q - LW'(1);
      2'b11:   level_d = level_q + LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: nothing is visible until level is non-zero.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    lane_q <= lane_d;
  end

  // Unsigned level, so an underflow also shows up as a value above DEPTH.
  a_level_bound : assert property (@(posedge clk) disable iff (!reset)
    level_q <= LW'(DEPTH));

endmodule
